// File: rtl/mul16_sequencer.sv
// ---------------------------------------------------------------------------
// mul16_sequencer
//   Multi-cycle unsigned shift-and-add multiplier. One shared WIDTH-bit ripple
//   adder built from full_adder cells is stepped through WIDTH iterations to
//   form a 2*WIDTH-bit product.
//
//   Ports:
//     clk      in   system clock, rising-edge
//     rst_n    in   asynchronous active-low reset
//     start    in   request, sampled in IDLE or DONE
//     a        in   WIDTH    multiplicand, captured on the accepting edge
//     b        in   WIDTH    multiplier, captured on the accepting edge
//     busy     out  high while in RUN
//     done     out  one-cycle pulse, product new and valid
//     product  out  2*WIDTH  last completed result
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start
//   RUN    | one add-and-shift iteration per cycle, WIDTH cycles
//   DONE   | product just updated; start here chains the next operation
// ---------------------------------------------------------------------------

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// WIDTH-bit ripple-carry adder; carry-out is returned as sum[WIDTH].
module ripple_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .x  (x[i]),
                .y  (y[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    assign sum[WIDTH] = carry[WIDTH];
endmodule

module mul16_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] l;
    logic [CW-1:0]    count;

    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    assign addend = l[0] ? mcand : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .x   (h),
        .y   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == LAST) begin
                    last     = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: the carry-out (sum[WIDTH]) shifts into the top of h so the
    // full 2*WIDTH-bit result is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            h       <= '0;
            l       <= '0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            mcand <= a;
            h     <= '0;
            l     <= b;
            count <= '0;
        end else if (step) begin
            h     <= sum[WIDTH:1];
            l     <= {sum[0], l[WIDTH-1:1]};
            count <= count + CW'(1);
            if (last) begin
                product <= {sum[WIDTH:1], sum[0], l[WIDTH-1:1]};
            end
        end
    end

endmodule
